// File: rtl/ram_initiator_pkg.sv
// Shared types and constants for the ram_initiator slice: bus widths, access sizes, FSM states.
// Also holds the alignment rule applied when misaligned accesses are trapped.
package ram_initiator_pkg;

  localparam int ADDR_BUS_W = 32;
  localparam int DATA_BUS_W = 32;

  typedef enum logic [1:0] {
    MEM_SIZE_BYTE = 2'b00,
    MEM_SIZE_HALF = 2'b01,
    MEM_SIZE_WORD = 2'b10,
    MEM_SIZE_RSVD = 2'b11
  } mem_size_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCESS,
    ST_GAP,
    ST_RESP
  } state_t;

  function automatic logic is_misaligned(input mem_size_t size, input logic [1:0] off);
    case (size)
      MEM_SIZE_BYTE: is_misaligned = 1'b0;
      MEM_SIZE_HALF: is_misaligned = off[0];
      MEM_SIZE_WORD: is_misaligned = (off != 2'b00);
      default:       is_misaligned = 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/ram_initiator_if.sv
// Request/response and RAM-side signals of ram_initiator grouped as one bundle.
// master = the initiator itself, slave = pipeline MEM stage plus RAM model.
interface ram_initiator_if;
  import ram_initiator_pkg::*;

  logic                  req_valid;
  logic                  req_ready;
  logic                  req_write;
  logic [1:0]            req_size;
  logic                  req_signed;
  logic [ADDR_BUS_W-1:0] req_addr;
  logic [DATA_BUS_W-1:0] req_wdata;
  logic                  resp_valid;
  logic [DATA_BUS_W-1:0] resp_rdata;
  logic                  resp_err;
  logic                  ram_en;
  logic                  ram_write_en;
  logic [3:0]            ram_write_sel;
  logic [ADDR_BUS_W-1:0] ram_addr;
  logic [DATA_BUS_W-1:0] ram_wdata;
  logic [DATA_BUS_W-1:0] ram_rdata;

  modport master (
    input  req_valid, req_write, req_size, req_signed, req_addr, req_wdata, ram_rdata,
    output req_ready, resp_valid, resp_rdata, resp_err,
           ram_en, ram_write_en, ram_write_sel, ram_addr, ram_wdata
  );

  modport slave (
    output req_valid, req_write, req_size, req_signed, req_addr, req_wdata, ram_rdata,
    input  req_ready, resp_valid, resp_rdata, resp_err,
           ram_en, ram_write_en, ram_write_sel, ram_addr, ram_wdata
  );

endinterface

// File: rtl/ram_initiator_mem_lane_align.sv
// mem_lane_align: little-endian byte-lane strobes, store-data replication and load extract/extend.
// Purely combinational; off is the byte offset within the addressed word.
module mem_lane_align
  import ram_initiator_pkg::*;
(
  input  mem_size_t              size,
  input  logic [1:0]             off,
  input  logic                   is_signed,
  input  logic [DATA_BUS_W-1:0]  wdata,
  input  logic [DATA_BUS_W-1:0]  rdata,
  output logic [3:0]             sel,
  output logic [DATA_BUS_W-1:0]  wdata_rep,
  output logic [DATA_BUS_W-1:0]  rdata_ext
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  assign lane_b = rdata[{off, 3'b000} +: 8];
  assign lane_h = off[1] ? rdata[31:16] : rdata[15:0];

  always_comb begin
    sel       = 4'b0000;
    wdata_rep = '0;
    rdata_ext = '0;
    case (size)
      MEM_SIZE_BYTE: begin
        sel       = 4'b0001 << off;
        wdata_rep = {4{wdata[7:0]}};
        rdata_ext = is_signed ? {{24{lane_b[7]}}, lane_b} : {24'b0, lane_b};
      end
      MEM_SIZE_HALF: begin
        sel       = off[1] ? 4'b1100 : 4'b0011;
        wdata_rep = {2{wdata[15:0]}};
        rdata_ext = is_signed ? {{16{lane_h[15]}}, lane_h} : {16'b0, lane_h};
      end
      default: begin
        sel       = 4'b1111;
        wdata_rep = wdata;
        rdata_ext = rdata;
      end
    endcase
  end

endmodule

// File: rtl/ram_initiator.sv
// ram_initiator: one-at-a-time load/store initiator for the word-organised RAM bus.
// Build option RAM_INIT_MISALIGN_TRAP_EN: misaligned/reserved accesses get an error response, no RAM access.
//
// state  | meaning
// IDLE   | ready for a request, RAM bus idle
// ACCESS | RAM enabled; down-counter holds cycles left in the access
// GAP    | one idle cycle after a write so the strobe falls before any next write
// RESP   | one-cycle response pulse
module ram_initiator
  import ram_initiator_pkg::*;
#(
  parameter int RD_LATENCY = 1,
  parameter int WR_HOLD    = 2
) (
  input logic              clk,
  input logic              rst,
  ram_initiator_if.master  bus
);

  localparam int CNT_W = 8;

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q;
  logic [ADDR_BUS_W-1:0] addr_q;
  mem_size_t             size_q;
  logic                  signed_q;
  logic                  write_q;
  logic                  err_q;
  logic [DATA_BUS_W-1:0] wdata_q;
  logic [DATA_BUS_W-1:0] rdata_q;

  logic                  accept;
  logic                  req_err;
  logic                  last_cycle;
  logic [3:0]            lane_sel;
  logic [DATA_BUS_W-1:0] lane_wdata;
  logic [DATA_BUS_W-1:0] lane_rdata;

`ifdef RAM_INIT_MISALIGN_TRAP_EN
  assign req_err = is_misaligned(mem_size_t'(bus.req_size), bus.req_addr[1:0]);
`else
  assign req_err = 1'b0;
`endif

  assign accept     = (state_q == ST_IDLE) && bus.req_valid;
  assign last_cycle = (state_q == ST_ACCESS) && (cnt_q == CNT_W'(1));

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (bus.req_valid) state_d = req_err ? ST_RESP : ST_ACCESS;
      ST_ACCESS: if (cnt_q == CNT_W'(1)) state_d = write_q ? ST_GAP : ST_RESP;
      ST_GAP:    state_d = ST_RESP;
      ST_RESP:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      addr_q   <= '0;
      size_q   <= MEM_SIZE_BYTE;
      signed_q <= 1'b0;
      write_q  <= 1'b0;
      err_q    <= 1'b0;
      wdata_q  <= '0;
      rdata_q  <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        addr_q   <= bus.req_addr;
        // Without trapping, the reserved size behaves as a word access.
        size_q   <= (mem_size_t'(bus.req_size) == MEM_SIZE_RSVD) ? MEM_SIZE_WORD
                                                                 : mem_size_t'(bus.req_size);
        signed_q <= bus.req_signed;
        write_q  <= bus.req_write;
        err_q    <= req_err;
        wdata_q  <= bus.req_wdata;
        cnt_q    <= bus.req_write ? CNT_W'(WR_HOLD) : CNT_W'(RD_LATENCY);
      end else if ((state_q == ST_ACCESS) && !last_cycle) begin
        cnt_q <= cnt_q - CNT_W'(1);
      end
      if (last_cycle && !write_q) rdata_q <= bus.ram_rdata;
    end
  end

  mem_lane_align u_lane_align (
    .size      (size_q),
    .off       (addr_q[1:0]),
    .is_signed (signed_q),
    .wdata     (wdata_q),
    .rdata     (rdata_q),
    .sel       (lane_sel),
    .wdata_rep (lane_wdata),
    .rdata_ext (lane_rdata)
  );

  assign bus.req_ready     = (state_q == ST_IDLE) && !rst;
  assign bus.resp_valid    = (state_q == ST_RESP);
  assign bus.resp_err      = (state_q == ST_RESP) && err_q;
  assign bus.resp_rdata    = ((state_q == ST_RESP) && !write_q && !err_q) ? lane_rdata : '0;
  assign bus.ram_en        = (state_q == ST_ACCESS);
  assign bus.ram_write_en  = (state_q == ST_ACCESS) && write_q;
  assign bus.ram_write_sel = ((state_q == ST_ACCESS) && write_q) ? lane_sel : 4'b0000;
  assign bus.ram_addr      = (state_q == ST_ACCESS) ? {addr_q[31:2], 2'b00} : '0;
  assign bus.ram_wdata     = ((state_q == ST_ACCESS) && write_q) ? lane_wdata : '0;

endmodule
